io_bank: RTL and testbench
==========================

// Module: io_bank
// PURPOSE
//  Parametrised memory-mapped IO peripheral; successor to the single-register switch/7-seg IO port.
//  Sits on the 8-bit CPU IO bus (ioSelect/ioAddress/ioNOE/ioNWE) in a 16-byte window at BASE_ADDR.
//  Provides debounced multi-byte switch inputs and rise/fall edge-capture flags (write-1-to-clear).
//  Provides N_OUT read/write output registers exported flat to display/LED drivers.
// PARAMETERS
//  BASE_ADDR   8'h00  window base; low nibble must be 0; hit = i_ioAddress[7:4]==BASE_ADDR[7:4]
//  N_SW_BYTES  1      switch input bytes, 1..4
//  N_OUT       1      output registers, 1..7
//  DEB_CYCLES  1000   clocks between debounce samples, >=2
//  OUT_RST     8'h00  reset value of every output register
// PORTS
//  i_clk       in   1             system clock
//  i_reset     in   1             synchronous reset, active-high
//  i_bus       in   8             write data from CPU bus
//  o_bus       out  8             read data to CPU bus
//  o_busNOE    out  1             active-low bus drive enable
//  i_ioSelect  in   1             IO space select
//  i_ioAddress in   8             IO address
//  i_ioNOE     in   1             active-low read strobe
//  i_ioNWE     in   1             active-low write strobe
//  i_switches  in   8*N_SW_BYTES  raw asynchronous switch inputs
//  o_outData   out  8*N_OUT       output registers; reg k at [8k+7:8k]
//  o_irq       out  1             level interrupt (see CONFIGURATION)
// BEHAVIOUR
//  Map (offset = i_ioAddress[3:0]); valid = hit & i_ioSelect & offset implemented:
//   0x0..0x3  SW[n]    RO  debounced switch byte n (n<N_SW_BYTES)
//   0x4..0x7  FLAG[n]  R/W1C edge flags for byte n
//   0x8..0xE  OUT[k]   RW  output reg k (k<N_OUT), readback = stored value
//   0xF       CTRL     RW  bit0 capture-rise, bit1 capture-fall, bit7 irq-enable; other bits read 0
//  Read: o_busNOE = ~valid | i_ioNOE, combinational; o_bus = mux of current register values,
//   8'h00 when not valid; reads have no side effects. Unimplemented offsets: never drive, writes ignored.
//  Write: on posedge i_clk when valid & ~i_ioNWE; takes effect next cycle. RO writes ignored.
//  Debounce: 2-FF synchroniser on every switch bit -> sync. Tick counter 0..DEB_CYCLES-1 wraps;
//   tick when counter==DEB_CYCLES-1. On tick: prev<=sync; per bit deb<=(sync==prev)?sync:deb.
//   Stable input change visible in SW after at most 2+2*DEB_CYCLES+1 clocks; glitch shorter than
//   DEB_CYCLES never reaches deb.
//  Edges: rise=deb_next&~deb, fall=~deb_next&deb in the cycle deb updates.
//   FLAG |= (rise&{CTRL[0]}) | (fall&{CTRL[1]}). W1C: FLAG &= ~i_bus on FLAG write.
//   Same-cycle set and W1C clear on one bit: set wins (flag stays 1).
//  Reset (i_reset high at posedge, any cycle incl. mid-debounce): sync,prev,deb,FLAG,counter=0;
//   OUT[k]=OUT_RST; CTRL=8'h03; o_irq=0. o_bus/o_busNOE stay combinational on reset state.
//   Switches held high through reset: deb rises after release -> rise flag set (intended).
// CONFIGURATION
//  IO_BANK_IRQ_EN defined: o_irq = CTRL[7] & |FLAG (all bytes), registered, 1 clock after FLAG/CTRL
//   change; stays high until all flags cleared or CTRL[7]=0.
//  Not defined: o_irq tied 0; CTRL[7] not stored, reads 0, writes ignored.
// TESTING (DEB_CYCLES=4, N_SW_BYTES=2, N_OUT=3, BASE_ADDR=8'h20, IO_BANK_IRQ_EN defined)
//  Reset, read 0x20,0x24,0x28,0x2F -> 8'h00,8'h00,OUT_RST,8'h03; read 0x23/0x2B -> o_busNOE=1.
//  Write 0x2A=8'hA5, then 0x29=8'h3C -> o_outData[23:16]=A5, [15:8]=3C; read back 0x2A -> A5.
//  i_switches 16'h0000->16'h0180 held -> SW0=80, SW1=01 within 11 clocks; FLAG0=80, FLAG1=01.
//  3-clock pulse on i_switches[0] -> SW0[0] never 1, FLAG0[0] stays 0.
//  CTRL=8'h83 with flags pending -> o_irq=1; write 0x24=80, 0x25=01 -> o_irq=0 next clock.
//  W1C on FLAG0 bit in same cycle as new rise on that bit -> flag reads 1; reset mid-debounce -> all 0.

Source files
------------

// File: rtl/io_bank_if.sv
// CPU IO bus bundle for io_bank: select/address/strobes plus both data directions.
interface io_bank_if;
  logic [7:0] i_bus;
  logic [7:0] o_bus;
  logic       o_busNOE;
  logic       i_ioSelect;
  logic [7:0] i_ioAddress;
  logic       i_ioNOE;
  logic       i_ioNWE;

  modport master (
    output i_bus, i_ioSelect, i_ioAddress, i_ioNOE, i_ioNWE,
    input  o_bus, o_busNOE
  );

  modport slave (
    input  i_bus, i_ioSelect, i_ioAddress, i_ioNOE, i_ioNWE,
    output o_bus, o_busNOE
  );
endinterface

// File: rtl/io_bank.sv
// Memory-mapped IO bank: debounced switch bytes, W1C edge flags, output registers, CTRL.
// Optional level interrupt on pending flags is built when IO_BANK_IRQ_EN is defined.
module io_bank #(
  parameter logic [7:0] BASE_ADDR  = 8'h00,
  parameter int         N_SW_BYTES = 1,
  parameter int         N_OUT      = 1,
  parameter int         DEB_CYCLES = 1000,
  parameter logic [7:0] OUT_RST    = 8'h00
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  io_bank_if.slave                bus,
  input  logic [8*N_SW_BYTES-1:0] i_switches,
  output logic [8*N_OUT-1:0]      o_outData,
  output logic                    o_irq
);

  localparam int SW_W = 8 * N_SW_BYTES;
  localparam int CW   = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic [3:0]      offset;
  logic            hit;
  logic            impl;
  logic            valid;
  logic            wr_en;
  logic [7:0]      rdata;

  logic [SW_W-1:0] sync_meta;
  logic [SW_W-1:0] sync_q;
  logic [SW_W-1:0] prev_q;
  logic [SW_W-1:0] deb_q;
  logic [SW_W-1:0] deb_next;
  logic [SW_W-1:0] flag_q;
  logic [SW_W-1:0] flag_next;
  logic [SW_W-1:0] clr_mask;
  logic [SW_W-1:0] rise;
  logic [SW_W-1:0] fall;
  logic [CW-1:0]   cnt_q;
  logic            tick;

  logic            ctrl_rise;
  logic            ctrl_fall;
  logic            ctrl_irq;
  logic [7:0]      out_q [N_OUT];

  // Address decode: only implemented offsets inside the window count as valid
  always_comb begin
    offset = bus.i_ioAddress[3:0];
    hit    = (bus.i_ioAddress[7:4] == BASE_ADDR[7:4]);
    impl   = (offset == 4'hF);
    for (int unsigned n = 0; n < N_SW_BYTES; n++) begin
      if (offset == 4'(n) || offset == 4'(n + 4)) impl = 1'b1;
    end
    for (int unsigned k = 0; k < N_OUT; k++) begin
      if (offset == 4'(k + 8)) impl = 1'b1;
    end
    valid = hit & bus.i_ioSelect & impl;
  end

  assign wr_en = valid & ~bus.i_ioNWE;
  assign tick  = (cnt_q == CNT_MAX);

  // A bit only follows sync when it matched the previous tick's sample
  always_comb begin
    deb_next = deb_q;
    if (tick) begin
      deb_next = (sync_q & ~(sync_q ^ prev_q)) | (deb_q & (sync_q ^ prev_q));
    end
  end

  // Set terms are OR-ed after the clear, so a same-cycle edge beats W1C
  always_comb begin
    clr_mask = '0;
    for (int unsigned n = 0; n < N_SW_BYTES; n++) begin
      if (wr_en && offset == 4'(n + 4)) clr_mask[8*n +: 8] = bus.i_bus;
    end
    rise      = deb_next & ~deb_q;
    fall      = ~deb_next & deb_q;
    flag_next = (flag_q & ~clr_mask)
              | (rise & {SW_W{ctrl_rise}})
              | (fall & {SW_W{ctrl_fall}});
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync_meta <= '0;
      sync_q    <= '0;
      prev_q    <= '0;
      deb_q     <= '0;
      flag_q    <= '0;
      cnt_q     <= '0;
      ctrl_rise <= 1'b1;
      ctrl_fall <= 1'b1;
    end else begin
      sync_meta <= i_switches;
      sync_q    <= sync_meta;
      cnt_q     <= tick ? '0 : cnt_q + 1'b1;
      if (tick) prev_q <= sync_q;
      deb_q     <= deb_next;
      flag_q    <= flag_next;
      if (wr_en && offset == 4'hF) begin
        ctrl_rise <= bus.i_bus[0];
        ctrl_fall <= bus.i_bus[1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    for (int unsigned k = 0; k < N_OUT; k++) begin
      if (i_reset) begin
        out_q[k] <= OUT_RST;
      end else if (wr_en && offset == 4'(k + 8)) begin
        out_q[k] <= bus.i_bus;
      end
    end
  end

  always_comb begin
    o_outData = '0;
    for (int unsigned k = 0; k < N_OUT; k++) begin
      o_outData[8*k +: 8] = out_q[k];
    end
  end

`ifdef IO_BANK_IRQ_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ctrl_irq <= 1'b0;
      o_irq    <= 1'b0;
    end else begin
      if (wr_en && offset == 4'hF) ctrl_irq <= bus.i_bus[7];
      o_irq <= ctrl_irq & (|flag_q);
    end
  end
`else
  assign ctrl_irq = 1'b0;
  assign o_irq    = 1'b0;
`endif

  always_comb begin
    rdata = 8'h00;
    for (int unsigned n = 0; n < N_SW_BYTES; n++) begin
      if (offset == 4'(n))     rdata = deb_q[8*n +: 8];
      if (offset == 4'(n + 4)) rdata = flag_q[8*n +: 8];
    end
    for (int unsigned k = 0; k < N_OUT; k++) begin
      if (offset == 4'(k + 8)) rdata = out_q[k];
    end
    if (offset == 4'hF) rdata = {ctrl_irq, 5'b00000, ctrl_fall, ctrl_rise};
  end

  assign bus.o_bus    = valid ? rdata : 8'h00;
  assign bus.o_busNOE = ~valid | bus.i_ioNOE;

endmodule

// File: tb/tb_io_bank.sv
// Randomized scoreboard bench for io_bank; reads are predicted by a settle-level model
// and popped by a monitor whenever the DUT drives the bus.
module tb_io_bank;
  localparam logic [7:0] BASE   = 8'h20;
  localparam int         NSW    = 2;
  localparam int         NOUT   = 3;
  localparam int         DEB    = 4;
  localparam logic [7:0] ORST   = 8'h5A;
  localparam int         SETTLE = 2 + 2*DEB + 1;
`ifdef IO_BANK_IRQ_EN
  localparam logic       IRQ_BUILD = 1'b1;
`else
  localparam logic       IRQ_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sw;
  logic [23:0] out_data;
  logic        irq;

  io_bank_if bus();

  io_bank #(
    .BASE_ADDR (BASE),
    .N_SW_BYTES(NSW),
    .N_OUT     (NOUT),
    .DEB_CYCLES(DEB),
    .OUT_RST   (ORST)
  ) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .bus       (bus),
    .i_switches(sw),
    .o_outData (out_data),
    .o_irq     (irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0]  m_out [NOUT];
  logic [15:0] m_sw;
  logic [15:0] m_flag;
  logic [7:0]  m_ctrl;
  logic [7:0]  exp_q [$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_sw   = '0;
    m_flag = '0;
    m_ctrl = 8'h03;
    for (int k = 0; k < NOUT; k++) m_out[k] = ORST;
  endtask

  // {valid, data} seen by a read of addr
  function automatic logic [8:0] model_read(input logic [7:0] addr);
    int o;
    o = int'(addr[3:0]);
    if (addr[7:4] != BASE[7:4])          return 9'h000;
    if (o < NSW)                         return {1'b1, 8'(m_sw >> (8*o))};
    if (o >= 4 && o < 4 + NSW)           return {1'b1, 8'(m_flag >> (8*(o-4)))};
    if (o >= 8 && o < 8 + NOUT)          return {1'b1, m_out[o-8]};
    if (o == 15)                         return {1'b1, m_ctrl};
    return 9'h000;
  endfunction

  function automatic void model_write(input logic [7:0] addr, input logic [7:0] data);
    int o;
    o = int'(addr[3:0]);
    if (addr[7:4] != BASE[7:4]) return;
    if (o >= 4 && o < 4 + NSW)  m_flag = m_flag & ~(16'(data) << (8*(o-4)));
    if (o >= 8 && o < 8 + NOUT) m_out[o-8] = data;
    if (o == 15)                m_ctrl = data & (IRQ_BUILD ? 8'h83 : 8'h03);
  endfunction

  function automatic void model_settle(input logic [15:0] v);
    logic [15:0] r, f;
    r = v & ~m_sw;
    f = ~v & m_sw;
    m_flag = m_flag | (r & {16{m_ctrl[0]}}) | (f & {16{m_ctrl[1]}});
    m_sw   = v;
  endfunction

  task automatic bus_idle();
    bus.i_ioSelect  = 1'b0;
    bus.i_ioAddress = 8'h00;
    bus.i_ioNOE     = 1'b1;
    bus.i_ioNWE     = 1'b1;
    bus.i_bus       = 8'h00;
  endtask

  // Monitor: every cycle the DUT drives a pure read, pop the oldest prediction
  always @(negedge clk) begin
    if (bus.o_busNOE === 1'b0 && bus.i_ioNWE === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_drive addr=%h got=%h expected no drive", bus.i_ioAddress, bus.o_bus);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.o_bus !== e) begin
          errors++;
          $display("FAIL read addr=%h got=%h expected=%h", bus.i_ioAddress, bus.o_bus, e);
        end
      end
    end
  end

  task automatic do_read(input logic [7:0] addr, input bit wait_edge);
    logic [8:0] r;
    r = model_read(addr);
    if (wait_edge) @(posedge clk);
    #1;
    bus.i_ioSelect  = 1'b1;
    bus.i_ioAddress = addr;
    bus.i_ioNOE     = 1'b0;
    if (r[8]) exp_q.push_back(r[7:0]);
    @(negedge clk);
    #1;
    if (!r[8]) begin
      check($sformatf("no_drive_%h", addr), {31'd0, bus.o_busNOE}, 32'd1);
      check($sformatf("idle_bus_%h", addr), {24'd0, bus.o_bus}, 32'd0);
    end else begin
      check($sformatf("read_taken_%h", addr), exp_q.size(), 32'd0);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
    bus_idle();
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [7:0] data);
    @(posedge clk);
    #1;
    bus.i_ioSelect  = 1'b1;
    bus.i_ioAddress = addr;
    bus.i_bus       = data;
    bus.i_ioNWE     = 1'b0;
    @(posedge clk);
    #1;
    bus_idle();
    model_write(addr, data);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic check_outputs();
    @(negedge clk);
    check("out_data", {8'd0, out_data}, {8'd0, m_out[2], m_out[1], m_out[0]});
    check("irq", {31'd0, irq}, {31'd0, IRQ_BUILD & m_ctrl[7] & (|m_flag)});
  endtask

  // Leaves the caller just after the SETTLE-th edge following the change
  task automatic set_switches(input logic [15:0] v);
    @(posedge clk);
    #1;
    sw = v;
    repeat (SETTLE) @(posedge clk);
    model_settle(v);
  endtask

  task automatic glitch(input logic [15:0] mask, input int len);
    @(posedge clk);
    #1;
    sw = m_sw ^ mask;
    repeat (len) @(posedge clk);
    #1;
    sw = m_sw;
    repeat (SETTLE + 1) @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    bit seen;
    logic [7:0] a;
    rst = 1'b1;
    sw  = '0;
    bus_idle();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs();

    // Reset values and decode boundaries
    do_read(8'h20, 1); do_read(8'h24, 1); do_read(8'h28, 1); do_read(8'h2F, 1);
    do_read(8'h21, 1); do_read(8'h25, 1); do_read(8'h2A, 1);
    do_read(8'h23, 1); do_read(8'h2B, 1); do_read(8'h26, 1); do_read(8'h30, 1);

    do_write(8'h2A, 8'hA5);
    do_write(8'h29, 8'h3C);
    do_write(8'h23, 8'hFF);
    do_write(8'h20, 8'hFF);
    check_outputs();
    do_read(8'h2A, 1); do_read(8'h20, 1);

    // Stable change observed exactly at the latency bound
    set_switches(16'h0180);
    do_read(8'h20, 0);
    do_read(8'h21, 1); do_read(8'h24, 1); do_read(8'h25, 1);

    glitch(16'h0001, DEB - 1);
    do_read(8'h20, 1); do_read(8'h24, 1);

    do_write(8'h2F, 8'h83);
    idle(2);
    check_outputs();
    do_read(8'h2F, 1);
    do_write(8'h24, 8'h80);
    idle(1);
    check_outputs();
    do_write(8'h25, 8'h01);
    idle(1);
    check_outputs();

    // Continuous W1C on FLAG0 bit0 while that bit rises: set must win once
    @(posedge clk);
    #1;
    sw              = 16'h0181;
    bus.i_ioSelect  = 1'b1;
    bus.i_ioAddress = 8'h24;
    bus.i_bus       = 8'h01;
    bus.i_ioNWE     = 1'b0;
    bus.i_ioNOE     = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3*SETTLE && !seen; i++) begin
      @(negedge clk);
      seen = bus.o_bus[0];
    end
    #1;
    bus_idle();
    check("w1c_set_wins", {31'd0, seen}, 32'd1);
    model_settle(16'h0181);
    idle(SETTLE);
    do_read(8'h24, 1);
    do_read(8'h20, 1);

    // Reset in the middle of a debounce
    @(posedge clk);
    #1;
    sw = 16'hFFFF;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    do_read(8'h20, 1); do_read(8'h21, 1); do_read(8'h24, 1); do_read(8'h25, 1);
    do_read(8'h28, 1); do_read(8'h2F, 1);
    check_outputs();
    set_switches(16'hFFFF);
    do_read(8'h24, 1); do_read(8'h25, 1);

    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 5))
        0: set_switches(16'($urandom));
        1: glitch(16'($urandom_range(1, 16'hFFFF)), $urandom_range(1, DEB - 1));
        2: do_write(8'h28 + 8'($urandom_range(0, NOUT - 1)), 8'($urandom));
        3: do_write(8'h2F, 8'($urandom));
        4: do_write(8'h24 + 8'($urandom_range(0, 1)), 8'($urandom));
        default: begin
          a = {(($urandom_range(0, 3) == 0) ? 4'h3 : 4'h2), 4'($urandom)};
          do_read(a, 1);
        end
      endcase
      idle(2);
      check_outputs();
      a = {4'h2, 4'($urandom)};
      do_read(a, 1);
    end

    check("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
